bus_data_ram: RTL and testbench

//  Data-memory responder on the core's load/store bus: the slave end of the busAddr/busWData/busRData path.
//  APB-style two-phase handshake with WAIT_STATES programmable wait cycles, byte-addressable storage,

---
 rtl/bus_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/bus_data_ram.sv | 114 +++++++++++
 tb/tb_bus_data_ram.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for the load/store bus data memory: FSM states, funct3 size codes, captured request.
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  // Unsigned sizes only make sense for loads.
  function automatic logic size_illegal(input logic [2:0] size, input logic write);
    case (size)
      SZ_B, SZ_H, SZ_W: return 1'b0;
      SZ_BU, SZ_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane selection plus sign/zero extension for loads.
`default_nettype none

module lsu_lane_align
  import bus_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [15:0] half_sel;

  assign shifted  = rword >> {addr, 3'b000};
  assign half_sel = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    store_word = wdata;
    load_data  = 32'h0;
    misalign   = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        byte_en    = 4'b0001 << addr;
        store_word = {4{wdata[7:0]}};
        load_data  = size[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H, SZ_HU: begin
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata[15:0]}};
        load_data  = size[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misalign   = addr[0];
      end
      SZ_W: begin
        byte_en    = 4'b1111;
        store_word = wdata;
        load_data  = rword;
        misalign   = |addr;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bus_data_ram.sv
// Data-memory slave on the core load/store bus: two-phase handshake, programmable wait states,
// byte-lane stores and extended loads. Storage is four byte-wide synchronous-read arrays.
`default_nettype none

module bus_data_ram
  import bus_pkg::*;
#(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busEnable,
  input  logic        busWrite,
  input  logic [2:0]  busSize,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                state, state_next;
  req_t                  req;
  logic [3:0]            cnt;
  logic                  exec, setup;
  logic [31:0]           rword, store_word, load_data;
  logic [3:0]            byte_en, lane_we;
  logic                  misalign, out_of_range, err;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  assign setup = (state == IDLE) && busSel && !busEnable;

  always_comb begin
    state_next = state;
    exec       = 1'b0;
    case (state)
      IDLE:   if (busSel && !busEnable) state_next = ACCESS;
      ACCESS: begin
        if (!busSel) begin
          state_next = IDLE;
        end else if (busEnable && cnt == 4'd0) begin
          exec       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (setup) req <= '{addr: busAddr, write: busWrite, size: busSize, wdata: busWData};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      busReady <= 1'b0;
      busErr   <= 1'b0;
      busRData <= 32'h0;
    end else begin
      busReady <= exec;
      busErr   <= exec && err;
      if (setup) cnt <= 4'(WAIT_STATES);
      else if (state == ACCESS && busSel && busEnable && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (exec) begin
        if (err)             busRData <= 32'h0;
        else if (!req.write) busRData <= load_data;
      end
    end
  end

  lsu_lane_align u_align (
    .size       (req.size),
    .addr       (req.addr[1:0]),
    .wdata      (req.wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  assign out_of_range = |req.addr[31:DEPTH_LOG2+2];
  assign err          = misalign || out_of_range || size_illegal(req.size, req.write);

  // Read address follows the bus during setup so the word is ready by the first access edge.
  assign rd_idx  = (state == IDLE) ? busAddr[DEPTH_LOG2+1:2] : req.addr[DEPTH_LOG2+1:2];
  assign wr_idx  = req.addr[DEPTH_LOG2+1:2];
  assign lane_we = (exec && !reset && req.write && !err) ? byte_en : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (lane_we[i]) mem[wr_idx] <= store_word[8*i +: 8];
      q <= mem[rd_idx];
    end
    assign rword[8*i +: 8] = q;
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_data_ram.sv
// Randomized check of bus_data_ram (WAIT_STATES 0 and 3) against a byte-array reference model.
`default_nettype none

module tb_bus_data_ram;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sel, en, wr, which;
  logic [2:0]  sz;
  logic [31:0] addr, wd;
  logic [31:0] rd0, rd3;
  logic        rdy0, rdy3, err0, err3;

  always #5 clk = ~clk;

  bus_data_ram #(.DEPTH_LOG2(10), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset), .busSel(sel & ~which), .busEnable(en), .busWrite(wr),
    .busSize(sz), .busAddr(addr), .busWData(wd), .busRData(rd0), .busReady(rdy0), .busErr(err0)
  );

  bus_data_ram #(.DEPTH_LOG2(10), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(reset), .busSel(sel & which), .busEnable(en), .busWrite(wr),
    .busSize(sz), .busAddr(addr), .busWData(wd), .busRData(rd3), .busReady(rdy3), .busErr(err3)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mdl    [2][4096];
  logic [31:0] exp_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d != 0) ? 3 : 0;
  endfunction

  // Reference: little-endian byte memory, size gives byte count, bit 2 of size means unsigned.
  task automatic model(input int d, input bit w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] data, output bit e);
    int n;
    logic [31:0] v;
    n = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    e = (s == 3'd3 || s == 3'd6 || s == 3'd7) || (w && s[2]) ||
        (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0) || (a >= 32'd4096);
    v = 32'h0;
    if (e) begin
      exp_rd[d] = 32'h0;
    end else if (w) begin
      for (int i = 0; i < n; i++) mdl[d][a + i] = data[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[d][a + i];
      if (!s[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rd[d] = v;
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [2:0] s, input logic [31:0] a,
                      input logic [31:0] data, input int hold_at, input int hold_len,
                      input string tag);
    bit          e, got_rdy;
    int          edges;
    logic [31:0] gotd;
    logic        gote;
    model(d, w, s, a, data, e);
    which = d[0]; sel = 1'b1; en = 1'b0; wr = w; sz = s; addr = a; wd = data;
    @(posedge clk); #1;
    edges = 1;
    // Bus inputs are scrambled during access; the captured request must be used.
    wr = 1'($urandom); sz = 3'($urandom); addr = $urandom; wd = $urandom;
    got_rdy = 1'b0;
    while (!got_rdy && edges < 60) begin
      en = !(edges >= hold_at && edges < hold_at + hold_len);
      @(posedge clk); #1;
      edges++;
      got_rdy = (d != 0) ? rdy3 : rdy0;
    end
    gotd = (d != 0) ? rd3 : rd0;
    gote = (d != 0) ? err3 : err0;
    sel = 1'b0; en = 1'b0;
    check({tag, " ready"}, 32'(got_rdy), 32'd1);
    check({tag, " latency"}, edges, 2 + ws(d) + hold_len);
    check({tag, " err"}, 32'(gote), 32'(e));
    check({tag, " rdata"}, gotd, exp_rd[d]);
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'((d != 0) ? rdy3 : rdy0), 32'd0);
  endtask

  task automatic abort_store(input int d, input logic [31:0] a, input logic [31:0] data);
    int seen;
    which = d[0]; sel = 1'b1; en = 1'b0; wr = 1'b1; sz = SZ_W; addr = a; wd = data;
    @(posedge clk); #1;
    sel = 1'b0; en = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (((d != 0) ? rdy3 : rdy0) === 1'b1) seen++;
    end
    en = 1'b0;
    check("abort no ready", seen, 0);
  endtask

  initial begin
    bit          w, hold_any;
    logic [2:0]  s;
    logic [31:0] a;
    int          d, hat, hlen;

    reset = 1'b1; sel = 1'b0; en = 1'b0; wr = 1'b0; sz = 3'd0; addr = 32'h0; wd = 32'h0; which = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready0", 32'(rdy0), 32'd0);
    check("reset err0", 32'(err0), 32'd0);
    check("reset rdata0", rd0, 32'd0);
    check("reset ready3", 32'(rdy3), 32'd0);
    check("reset err3", 32'(err3), 32'd0);
    check("reset rdata3", rd3, 32'd0);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    reset = 1'b0;

    for (int dd = 0; dd < 2; dd++)
      for (int k = 0; k < 64; k++) xfer(dd, 1'b1, SZ_W, 32'(4 * k), $urandom, 0, 0, "init");

    xfer(0, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 0, 0, "t1 sw");
    xfer(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, 0, "t1 lw");
    check("t1 lw const", rd0, 32'hDEAD_BEEF);

    xfer(0, 1'b1, SZ_B, 32'h13, 32'h0000_0080, 0, 0, "t2 sb");
    xfer(0, 1'b0, SZ_B, 32'h13, 32'h0, 0, 0, "t2 lb");
    check("t2 lb const", rd0, 32'hFFFF_FF80);
    xfer(0, 1'b0, SZ_BU, 32'h13, 32'h0, 0, 0, "t2 lbu");
    check("t2 lbu const", rd0, 32'h0000_0080);
    xfer(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, 0, "t2 lw");
    check("t2 lw const", rd0, 32'h80AD_BEEF);

    xfer(0, 1'b1, SZ_H, 32'h11, 32'h0000_5555, 0, 0, "t3 sh mis");
    check("t3 sh err", 32'(err0), 32'd0);
    xfer(0, 1'b0, SZ_W, 32'h10, 32'h0, 0, 0, "t3 lw");
    check("t3 unchanged", rd0, 32'h80AD_BEEF);
    xfer(0, 1'b0, SZ_W, 32'h1000, 32'h0, 0, 0, "t3 oor");
    check("t3 oor rdata", rd0, 32'h0);

    xfer(1, 1'b0, SZ_W, 32'h10, 32'h0, 0, 0, "t4 ws3");
    xfer(1, 1'b0, SZ_H, 32'h12, 32'h0, 2, 2, "t4 hold");

    abort_store(0, 32'h20, 32'h0000_1234);
    xfer(0, 1'b0, SZ_W, 32'h20, 32'h0, 0, 0, "t5 lw");
    abort_store(1, 32'h24, 32'h0000_1234);
    xfer(1, 1'b0, SZ_W, 32'h24, 32'h0, 0, 0, "t5 lw3");

    // Reset in the middle of a wait-stated store.
    which = 1'b1; sel = 1'b1; en = 1'b0; wr = 1'b1; sz = SZ_W; addr = 32'h30; wd = 32'hCAFE_F00D;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6 ready3", 32'(rdy3), 32'd0);
    check("t6 err3", 32'(err3), 32'd0);
    check("t6 rdata3", rd3, 32'd0);
    check("t6 rdata0", rd0, 32'd0);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    reset = 1'b0; sel = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, SZ_W, 32'h30, 32'h0, 0, 0, "t6 lw");

    for (int k = 0; k < 300; k++) begin
      d = int'($urandom_range(0, 1));
      w = 1'($urandom);
      s = 3'($urandom);
      a = (($urandom % 8) == 0) ? ($urandom | 32'h0000_1000) : ($urandom % 256);
      hold_any = (d != 0) && (($urandom % 2) == 0);
      hat  = hold_any ? int'($urandom_range(1, 4)) : 0;
      hlen = hold_any ? int'($urandom_range(0, 2)) : 0;
      xfer(d, w, s, a, $urandom, hat, hlen, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
